// File: rtl/arinc429_rx_deserializer.sv
// ARINC 429 receive deserializer: bipolar RZ line pair -> 32-bit words (first bit in word_out[0]), no backpressure.
// word_valid/rx_err pulse 1 clk after the deciding sample; define ARINC_RX_SYNC_EN to add a 2-flop input synchronizer (+2 clk).
module arinc429_rx_deserializer #(
    parameter int BIT_CLKS  = 80,
    parameter int SAMPLE_AT = 20,
    parameter int GAP_CLKS  = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_hi,
    input  logic        line_lo,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        rx_err,
    output logic        busy
);

    localparam int TMAX = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLE_AT);
    localparam logic [TW-1:0] T_BIT    = TW'(BIT_CLKS);
    localparam logic [TW-1:0] T_GAP    = TW'(GAP_CLKS);
    localparam logic [TW-1:0] T_SAT    = {TW{1'b1}};
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_PULSE, ST_NULL} state_t;

    logic hi, lo;
`ifdef ARINC_RX_SYNC_EN
    logic [1:0] hi_sync_q, lo_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_sync_q <= '0;
            lo_sync_q <= '0;
        end else begin
            hi_sync_q <= {hi_sync_q[0], line_hi};
            lo_sync_q <= {lo_sync_q[0], line_lo};
        end
    end

    assign hi = hi_sync_q[1];
    assign lo = lo_sync_q[1];
`else
    assign hi = line_hi;
    assign lo = line_lo;
`endif

    logic is_one, is_zero, is_null, active;
    assign is_one  = hi & ~lo;
    assign is_zero = lo & ~hi;
    assign is_null = ~hi & ~lo;
    assign active  = hi | lo;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   word_q, word_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;

    assign timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + T_ONE;

    // In PULSE/NULL timer_q is the offset of the current cycle from the start of
    // that pulse or null run; the cycle that opened the run is offset 0.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (active) begin
                    timer_d = '0;
                end else if (timer_inc >= T_GAP) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_IDLE: begin
                if (active) begin
                    state_d   = ST_PULSE;
                    timer_d   = T_ONE;
                    bit_cnt_d = '0;
                end
            end
            ST_PULSE: begin
                timer_d = timer_inc;
                if (timer_q < T_SAMPLE) begin
                    if (is_null) begin
                        err_d   = 1'b1;
                        state_d = ST_ARM;
                        timer_d = '0;
                    end
                end else if (timer_q == T_SAMPLE) begin
                    if (is_one | is_zero) begin
                        shift_d[bit_cnt_q[4:0]] = is_one;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd31) begin
                            word_d  = shift_d;
                            vld_d   = 1'b1;
                            state_d = ST_ARM;
                            timer_d = '0;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ARM;
                        timer_d = '0;
                    end
                end else if (is_null) begin
                    state_d = ST_NULL;
                    timer_d = T_ONE;
                end else if (timer_inc >= T_BIT) begin
                    err_d   = 1'b1;
                    state_d = ST_ARM;
                    timer_d = '0;
                end
            end
            ST_NULL: begin
                if (active) begin
                    state_d = ST_PULSE;
                    timer_d = T_ONE;
                end else if (timer_inc >= T_GAP) begin
                    err_d   = 1'b1;
                    state_d = ST_ARM;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = ST_ARM;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARM;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = vld_q;
    assign rx_err     = err_q;
    assign busy       = (state_q == ST_PULSE) || (state_q == ST_NULL);

endmodule

// File: tb/tb_arinc429_rx_deserializer.sv
// Directed bench for arinc429_rx_deserializer: a timeline model of expected pulses/busy per clock edge,
// checked every cycle, plus literal pins on words, counts and latencies.
module tb_arinc429_rx_deserializer;

    localparam int BC   = 8;
    localparam int SA   = 2;
    localparam int GC   = 32;
    localparam int NCYC = 4096;
`ifdef ARINC_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk, rst_n, line_hi, line_lo;
    logic [31:0] word_out;
    logic        word_valid, rx_err, busy;

    arinc429_rx_deserializer #(.BIT_CLKS(BC), .SAMPLE_AT(SA), .GAP_CLKS(GC)) dut (
        .clk(clk), .rst_n(rst_n), .line_hi(line_hi), .line_lo(line_lo),
        .word_out(word_out), .word_valid(word_valid), .rx_err(rx_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs after clock edge N, filled in by the stimulus tasks
    bit          exp_vld  [NCYC];
    bit          exp_err  [NCYC];
    bit          exp_busy [NCYC];
    logic [31:0] exp_wd   [NCYC];

    int n_cmp = 0, n_bad = 0;
    int n_vld = 0, n_err = 0, last_vld_e = 0, last_err_e = 0;
    logic [31:0] model_word = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_word = '0;
            chk("rst_word_out", word_out, 32'h0);
            chk("rst_word_valid", 32'(word_valid), 32'h0);
            chk("rst_rx_err", 32'(rx_err), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end else begin
            if (exp_vld[cyc]) model_word = exp_wd[cyc];
            chk("word_valid", 32'(word_valid), 32'(exp_vld[cyc]));
            chk("rx_err", 32'(rx_err), 32'(exp_err[cyc]));
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            chk("word_out", word_out, model_word);
        end
        if (word_valid) begin n_vld++; last_vld_e = cyc; end
        if (rx_err) begin n_err++; last_err_e = cyc; end
    end

    // one clock edge with the given line levels
    task automatic drive(input logic h, input logic l);
        line_hi = h;
        line_lo = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    // nbits bits of 4 pulse + 4 null cycles; bad_bit is driven hi=lo=1; reset held 3 cycles where rst_bit is due
    task automatic send_word(input logic [31:0] w, input int nbits, input int bad_bit,
                             input int rst_bit, output int e_first);
        bit alive;
        alive   = 1'b1;
        e_first = 0;
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rst_n = 1'b0;
                alive = 1'b0;
                #1;
                chk("rst_async_busy", 32'(busy), 32'h0);
                chk("rst_async_word", word_out, 32'h0);
                repeat (3) drive(1'b0, 1'b0);
                rst_n = 1'b1;
            end
            for (int k = 0; k < BC; k++) begin
                if (k >= BC / 2)      drive(1'b0, 1'b0);
                else if (b == bad_bit) drive(1'b1, 1'b1);
                else                  drive(w[b], !w[b]);
                if (b == 0 && k == 0) e_first = cyc;
                if (alive) begin
                    if (k == SA && b == bad_bit) begin
                        exp_err[cyc + LAT] = 1'b1;
                        alive = 1'b0;
                    end else if (k == SA && b == 31) begin
                        exp_vld[cyc + LAT] = 1'b1;
                        exp_wd[cyc + LAT]  = w;
                        alive = 1'b0;
                    end else if (k == BC / 2 - 1 && b == nbits - 1 && nbits < 32) begin
                        // short word: the GC-th null after the last pulse raises the error
                        for (int g = 0; g < GC; g++) exp_busy[cyc + g + LAT] = 1'b1;
                        exp_err[cyc + GC + LAT] = 1'b1;
                        alive = 1'b0;
                    end else begin
                        exp_busy[cyc + LAT] = 1'b1;
                    end
                end
            end
        end
    endtask

    int e0;

    initial begin
        rst_n   = 1'b0;
        line_hi = 1'b0;
        line_lo = 1'b0;
        repeat (3) drive(1'b0, 1'b0);
        rst_n = 1'b1;

        idle(GC);
        send_word(32'h0000_00A5, 32, -1, -1, e0);
        idle(GC);
        chk("a5_word", word_out, 32'h0000_00A5);
        chk("a5_vld_count", 32'(n_vld), 32'd1);
        chk("a5_latency", 32'(last_vld_e - e0), 32'(250 + LAT));
        chk("a5_no_err", 32'(n_err), 32'd0);

        send_word(32'h8000_0001, 32, -1, -1, e0);
        idle(GC);
        chk("b2b_first", word_out, 32'h8000_0001);
        send_word(32'h7FFF_FFFE, 32, -1, -1, e0);
        idle(GC);
        chk("b2b_second", word_out, 32'h7FFF_FFFE);
        chk("b2b_vld_count", 32'(n_vld), 32'd3);

        send_word(32'h000F_FFFF, 20, -1, -1, e0);
        idle(36);
        chk("short_err_count", 32'(n_err), 32'd1);
        chk("short_err_latency", 32'(last_err_e - e0), 32'(187 + LAT));
        chk("short_keeps_word", word_out, 32'h7FFF_FFFE);
        chk("short_busy", 32'(busy), 32'h0);
        idle(GC);

        send_word(32'hCAFE_F00D, 32, 5, -1, e0);
        chk("illegal_err_latency", 32'(last_err_e - e0), 32'(42 + LAT));
        idle(GC);
        send_word(32'h1234_5678, 32, -1, -1, e0);
        idle(GC);
        chk("after_illegal_word", word_out, 32'h1234_5678);
        chk("illegal_err_count", 32'(n_err), 32'd2);
        chk("illegal_vld_count", 32'(n_vld), 32'd4);

        drive(1'b1, 1'b0);
        exp_busy[cyc + LAT] = 1'b1;
        drive(1'b0, 1'b0);
        exp_err[cyc + LAT] = 1'b1;
        idle(40);
        chk("glitch_err_count", 32'(n_err), 32'd3);
        chk("glitch_vld_count", 32'(n_vld), 32'd4);

        send_word(32'h0F0F_0F0F, 32, -1, 17, e0);
        idle(GC);
        chk("rst_mid_no_word", word_out, 32'h0);
        send_word(32'h55AA_33CC, 32, -1, -1, e0);
        idle(GC);
        chk("after_rst_word", word_out, 32'h55AA_33CC);
        chk("after_rst_vld_count", 32'(n_vld), 32'd5);

        send_word(32'hDEAD_BEEF, 32, -1, -1, e0);
        idle(GC);
        chk("deadbeef_word", word_out, 32'hDEAD_BEEF);
        chk("deadbeef_latency", 32'(last_vld_e - e0), 32'(250 + LAT));
        chk("final_err_count", 32'(n_err), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
